// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: one Feistel round per clock, subkeys regenerated in reverse by right rotation.
// Optional key parity check enabled by defining DES_DEC_KEY_PARITY_EN (adds the key_err output).
module des_decrypt_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ciphertext,
  input  logic [63:0] keyInput,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plaintext
`ifdef DES_DEC_KEY_PARITY_EN
  ,
  output logic        key_err
`endif
);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // S-box entries in row-major order: index = {b5,b0} * 16 + b4..b1
  localparam int S_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [3:0]  rnd;
  logic [31:0] l, r, r_next;
  logic [27:0] c, d, c_rot, d_rot;
  logic [1:0]  shamt;
  logic [47:0] subkey;

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    ip_perm = '0;
    for (int i = 0; i < 64; i++) ip_perm[63-i] = x[6'(64 - IP_T[i])];
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    fp_perm = '0;
    for (int i = 0; i < 64; i++) fp_perm[63-i] = x[6'(64 - FP_T[i])];
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    pc1_perm = '0;
    for (int i = 0; i < 56; i++) pc1_perm[55-i] = x[6'(64 - PC1_T[i])];
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    pc2_perm = '0;
    for (int i = 0; i < 48; i++) pc2_perm[47-i] = x[6'(56 - PC2_T[i])];
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] s);
    case (s)
      2'd1:    rotr = {v[0], v[27:1]};
      2'd2:    rotr = {v[1:0], v[27:2]};
      default: rotr = v;
    endcase
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] rv, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    x = '0;
    s = '0;
    feistel = '0;
    for (int i = 0; i < 48; i++) x[47-i] = rv[5'(32 - E_T[i])];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b = x[47-6*j -: 6];
      s[31-4*j -: 4] = 4'(S_T[j][{b[5], b[0], b[4:1]}]);
    end
    for (int i = 0; i < 32; i++) feistel[31-i] = s[5'(32 - P_T[i])];
  endfunction

`ifdef DES_DEC_KEY_PARITY_EN
  function automatic logic parity_bad(input logic [63:0] k);
    parity_bad = 1'b0;
    for (int b = 0; b < 8; b++) if (~^k[8*b +: 8]) parity_bad = 1'b1;
  endfunction
`endif

  // PC-1 output already equals C16/D16, so round 0 uses it unrotated
  assign shamt  = (rnd == 4'd0) ? 2'd0 :
                  (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) ? 2'd1 : 2'd2;
  assign c_rot  = rotr(c, shamt);
  assign d_rot  = rotr(d, shamt);
  assign subkey = pc2_perm({c_rot, d_rot});
  assign r_next = l ^ feistel(r, subkey);

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= 4'd0;
      out_valid <= 1'b0;
      plaintext <= 64'h0;
      l         <= 32'h0;
      r         <= 32'h0;
      c         <= 28'h0;
      d         <= 28'h0;
`ifdef DES_DEC_KEY_PARITY_EN
      key_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          {l, r} <= ip_perm(ciphertext);
          {c, d} <= pc1_perm(keyInput);
          rnd    <= 4'd0;
          state  <= RUN;
`ifdef DES_DEC_KEY_PARITY_EN
          key_err <= parity_bad(keyInput);
`endif
        end
        RUN: begin
          l <= r;
          r <= r_next;
          c <= c_rot;
          d <= d_rot;
          if (rnd == 4'd15) begin
            plaintext <= fp_perm({r_next, r});
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Scoreboard bench for des_decrypt_iter: known-answer vectors, backpressure, mid-run reset and
// random round trips through a DES encryption model held in the bench.
module tb_des_decrypt_iter;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [63:0] ciphertext = '0;
  logic [63:0] keyInput = '0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [63:0] plaintext;
`ifdef DES_DEC_KEY_PARITY_EN
  logic        key_err;
`endif

  des_decrypt_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .keyInput(keyInput), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext)
`ifdef DES_DEC_KEY_PARITY_EN
    , .key_err(key_err)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference tables, DES bit numbering (1 = MSB), concatenated: IP, IP^-1, E, P, PC-1, PC-2
  localparam int OFF_IP = 0, OFF_FP = 64, OFF_E = 128, OFF_P = 176, OFF_PC1 = 208, OFF_PC2 = 264;
  localparam int TAB [312] = '{
    58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7,
    40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25,
    32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11, 12,13,12,13,14,15,16,17,16,17,18,19,20,21,20,21,
    22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1,
    16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25,
    57,49,41,33,25,17,9,1,58,50,42,34,26,18, 10,2,59,51,43,35,27,19,11,3,60,52,44,36,
    63,55,47,39,31,23,15,7,62,54,46,38,30,22, 14,6,61,53,45,37,29,21,13,5,28,20,12,4,
    14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4, 26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
    51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};
  localparam int LS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Generic table permutation: bit n of an inw-bit value lives at index inw-n
  function automatic logic [63:0] perm(input logic [63:0] x, input int inw, input int outw, input int off);
    logic [63:0] y = '0;
    for (int i = 0; i < outw; i++) y[outw-1-i] = x[inw - TAB[off+i]];
    return y;
  endfunction

  function automatic logic [31:0] fModel(input logic [31:0] rv, input logic [47:0] k);
    logic [63:0] t;
    logic [47:0] x;
    logic [31:0] s = '0;
    int v, row, col;
    t = perm({32'h0, rv}, 32, 48, OFF_E);
    x = t[47:0] ^ k;
    for (int j = 0; j < 8; j++) begin
      v   = int'((x >> (42 - 6*j)) & 48'h3f);
      row = ((v >> 4) & 2) | (v & 1);
      col = (v >> 1) & 15;
      s   = (s << 4) | 32'(SB[64*j + 16*row + col]);
    end
    t = perm({32'h0, s}, 32, 32, OFF_P);
    return t[31:0];
  endfunction

  // Textbook DES: forward key schedule with left rotations, then 16 rounds in either order
  function automatic logic [63:0] desModel(input logic [63:0] key, input logic [63:0] blk, input bit dec);
    logic [47:0] ks [16];
    logic [63:0] t;
    logic [27:0] c, d;
    logic [31:0] l, r, tmp;
    t = perm(key, 64, 56, OFF_PC1);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < LS[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t = perm({8'h0, c, d}, 56, 48, OFF_PC2);
      ks[i] = t[47:0];
    end
    t = perm(blk, 64, 64, OFF_IP);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      tmp = r;
      r   = l ^ fModel(r, ks[dec ? 15 - i : i]);
      l   = tmp;
    end
    return perm({r, l}, 64, 64, OFF_FP);
  endfunction

  function automatic logic keyParityBad(input logic [63:0] k);
    logic bad = 1'b0;
    for (int b = 0; b < 8; b++) if ($countones(k[8*b +: 8]) % 2 == 0) bad = 1'b1;
    return bad;
  endfunction

  typedef struct {
    logic [63:0] pt;
    logic        kerr;
    int          acc;
  } job_t;
  job_t sb[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Waits for in_ready, presents one job for one cycle, then scrambles the inputs
  task automatic applyStimulus(input logic [63:0] key, input logic [63:0] ct, input logic [63:0] pt,
                               input bit track, output int waited);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      reportFail("in_ready_timeout");
      return;
    end
    keyInput   = key;
    ciphertext = ct;
    in_valid   = 1;
    if (track) sb.push_back('{pt, keyParityBad(key), cyc + 1});
    @(posedge clk);
    @(negedge clk);
    in_valid   = 0;
    ciphertext = {$urandom, $urandom};
    keyInput   = {$urandom, $urandom};
  endtask

  // Monitor: latency on first valid, hold stability under backpressure, data on handshake
  logic        prev_valid = 0, prev_ready = 0;
  logic [63:0] held = '0;
  initial forever begin
    job_t j;
    @(negedge clk);
    #1;
    if (rst) begin
      prev_valid = 0;
    end else begin
      if (out_valid) begin
        if (!prev_valid) begin
          if (sb.size() == 0) reportFail("unexpected_out_valid");
          else checkOutput("latency", 64'(cyc - sb[0].acc), 64'd16);
        end else if (!prev_ready) begin
          checkOutput("plaintext_hold", plaintext, held);
        end
        if (out_ready && sb.size() > 0) begin
          j = sb.pop_front();
          checkOutput("plaintext", plaintext, j.pt);
`ifdef DES_DEC_KEY_PARITY_EN
          checkOutput("key_err", {63'h0, key_err}, {63'h0, j.kerr});
`endif
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
    end
    held = plaintext;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation hung");
  end

  localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] FIPS_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] FIPS_PT  = 64'h0123456789ABCDEF;

  initial begin
    int w, n;
    logic [63:0] k, p;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", {63'h0, in_ready}, 64'h0);
    checkOutput("reset_out_valid", {63'h0, out_valid}, 64'h0);
    checkOutput("reset_plaintext", plaintext, 64'h0);
`ifdef DES_DEC_KEY_PARITY_EN
    checkOutput("reset_key_err", {63'h0, key_err}, 64'h0);
`endif
    rst = 0;
    #1;
    checkOutput("post_reset_in_ready", {63'h0, in_ready}, 64'h1);

    $display("[TB] known-answer vectors");
    applyStimulus(FIPS_KEY, FIPS_CT, FIPS_PT, 1, w);
    applyStimulus(64'h0E329232EA6D0D73, 64'h0, 64'h8787878787878787, 1, w);

    $display("[TB] backpressure and back-to-back");
    applyStimulus(FIPS_KEY, FIPS_CT, FIPS_PT, 1, w);
    out_ready = 0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) reportFail("out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("in_ready_backpressure", {63'h0, in_ready}, 64'h0);
    end
    out_ready = 1;
    checkOutput("in_ready_done_released", {63'h0, in_ready}, 64'h0);
    applyStimulus(64'h0E329232EA6D0D73, 64'h0, 64'h8787878787878787, 1, w);
    checkOutput("reaccept_wait", 64'(w), 64'd0);

    $display("[TB] reset during run");
    applyStimulus(64'hFEDCBA9876543210, 64'h1122334455667788, 64'h0, 0, w);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checkOutput("abort_out_valid", {63'h0, out_valid}, 64'h0);
    checkOutput("abort_in_ready_in_reset", {63'h0, in_ready}, 64'h0);
    rst = 0;
    #1;
    checkOutput("abort_in_ready_after", {63'h0, in_ready}, 64'h1);
    repeat (25) @(negedge clk);
    applyStimulus(FIPS_KEY, FIPS_CT, FIPS_PT, 1, w);

`ifdef DES_DEC_KEY_PARITY_EN
    $display("[TB] key parity");
    applyStimulus(64'h123457799BBCDFF1, FIPS_CT, FIPS_PT, 1, w);
    applyStimulus(FIPS_KEY, FIPS_CT, FIPS_PT, 1, w);
`endif

    $display("[TB] random round trips");
    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom};
      p = {$urandom, $urandom};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(k, desModel(k, p, 1'b0), p, 1, w);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) reportFail("scoreboard_not_drained");
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
